// File: rtl/regbank_pkg.sv
// Shared types and helpers for the SIMD register bank: sweep FSM states,
// the default lane word, and the even-parity function used when REGBANK_PARITY_EN is defined.
package regbank_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int PAR_MAX_W = 1024;

  typedef enum logic {
    SWEEP = 1'b0,
    READY = 1'b1
  } state_t;

  typedef logic [DEF_WIDTH-1:0] lane_word_t;

  // Zero-extension keeps the parity unchanged, so any word up to PAR_MAX_W bits fits.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regbank_lane.sv
// One lane of the register bank: 1 write / 2 registered read ports with write-first forwarding.
// With REGBANK_PARITY_EN defined each word carries an even-parity bit that is checked on read.
module regbank_lane
  import regbank_pkg::*;
#(
  parameter int NREGS = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  fwd_en,
  input  logic                  hold,
  input  logic [1:0]            rd_en,
  input  logic [1:0][AW-1:0]    rd_addr,
  output logic [1:0][WIDTH-1:0] rd_data,
  output logic [1:0]            rd_valid,
  output logic [1:0]            rd_perr
);

`ifdef REGBANK_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = WIDTH + PW;
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [MW-1:0]         mem [NREGS];
  logic [MW-1:0]         wr_word;
  logic [1:0][MW-1:0]    raw;
  logic [1:0][WIDTH-1:0] rd_word;
  logic [1:0]            rd_err;

`ifdef REGBANK_PARITY_EN
  assign wr_word = {even_parity(PAR_MAX_W'(wr_data)), wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Storage array: no reset so it maps onto RAM; the sweep FSM clears it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Read data selection: out-of-range reads 0, same-cycle write is forwarded.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      raw[p]     = '0;
      rd_word[p] = '0;
      rd_err[p]  = 1'b0;
      if ({1'b0, rd_addr[p]} >= NREGS_W) begin
        rd_word[p] = '0;
      end else if (fwd_en && (wr_addr == rd_addr[p])) begin
        rd_word[p] = wr_data;
      end else begin
        raw[p]     = mem[rd_addr[p]];
        rd_word[p] = raw[p][WIDTH-1:0];
`ifdef REGBANK_PARITY_EN
        rd_err[p]  = even_parity(PAR_MAX_W'(raw[p][WIDTH-1:0])) ^ raw[p][WIDTH];
`endif
      end
    end
  end

  // Registered read outputs; data holds while the bank is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 2'b00;
      rd_perr  <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (hold) begin
          rd_valid[p] <= 1'b0;
          rd_perr[p]  <= 1'b0;
        end else if (rd_en[p]) begin
          rd_valid[p] <= 1'b1;
          rd_data[p]  <= rd_word[p];
          rd_perr[p]  <= rd_err[p];
        end else begin
          rd_valid[p] <= 1'b0;
          rd_data[p]  <= '0;
          rd_perr[p]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regbank_sync_rd.sv
// Multi-lane SIMD register bank with sweep-to-zero FSM, shared addresses and per-lane enables.
// Optional per-word parity when REGBANK_PARITY_EN is defined; otherwise par_err_* stay 0.
module regbank_sync_rd
  import regbank_pkg::*;
#(
  parameter int LANES = 16,
  parameter int NREGS = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  output logic                   busy,
  input  logic [LANES-1:0]       write_en,
  input  logic [AW-1:0]          waddr,
  input  logic [LANES*WIDTH-1:0] wdata,
  input  logic [LANES-1:0]       read_en_0,
  input  logic [AW-1:0]          raddr_0,
  output logic [LANES*WIDTH-1:0] rdata_0,
  output logic [LANES-1:0]       rvalid_0,
  input  logic [LANES-1:0]       read_en_1,
  input  logic [AW-1:0]          raddr_1,
  output logic [LANES*WIDTH-1:0] rdata_1,
  output logic [LANES-1:0]       rvalid_1,
  output logic [LANES-1:0]       par_err_0,
  output logic [LANES-1:0]       par_err_1
);

  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);

  state_t        state, next_state;
  logic [AW-1:0] ptr, next_ptr;
  logic          sweeping;
  logic          hold;
  logic          waddr_ok;

  // Sweep FSM next-state: walk every address once, restart on clr.
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      SWEEP: begin
        if (clr) begin
          next_ptr = '0;
        end else if (ptr == LAST) begin
          next_state = READY;
          next_ptr   = '0;
        end else begin
          next_ptr = ptr + 1'b1;
        end
      end
      READY: begin
        if (clr) begin
          next_state = SWEEP;
          next_ptr   = '0;
        end else begin
          next_state = READY;
          next_ptr   = '0;
        end
      end
      default: begin
        next_state = SWEEP;
        next_ptr   = '0;
      end
    endcase
  end

  // Sweep FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= next_state;
      ptr   <= next_ptr;
    end
  end

  assign sweeping = (state == SWEEP);
  assign busy     = sweeping;
  // A clr cycle drops accesses just like a sweep cycle does.
  assign hold     = sweeping | clr;
  assign waddr_ok = ({1'b0, waddr} < NREGS_W);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic                  user_we;
    logic [1:0][WIDTH-1:0] lane_rd;
    logic [1:0]            lane_vld;
    logic [1:0]            lane_err;

    assign user_we = write_en[i] & waddr_ok & ~hold;

    regbank_lane #(
      .NREGS (NREGS),
      .WIDTH (WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (sweeping | user_we),
      .wr_addr  (sweeping ? ptr : waddr),
      .wr_data  (sweeping ? '0 : wdata[i*WIDTH +: WIDTH]),
      .fwd_en   (user_we),
      .hold     (hold),
      .rd_en    ({read_en_1[i], read_en_0[i]}),
      .rd_addr  ({raddr_1, raddr_0}),
      .rd_data  (lane_rd),
      .rd_valid (lane_vld),
      .rd_perr  (lane_err)
    );

    assign rdata_0[i*WIDTH +: WIDTH] = lane_rd[0];
    assign rdata_1[i*WIDTH +: WIDTH] = lane_rd[1];
    assign rvalid_0[i]  = lane_vld[0];
    assign rvalid_1[i]  = lane_vld[1];
    assign par_err_0[i] = lane_err[0];
    assign par_err_1[i] = lane_err[1];
  end

endmodule
